// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Execute-stage branch comparator and resolver with a 2-bit saturating BHT.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pf_pc / o_pf_taken  fetch-side prediction lookup (combinational read)
//   i_rs_*                branch being resolved this cycle
//   o_res_*               registered resolve outcome, one cycle after i_rs_valid
//   o_cnt_branch          resolved legal branches (wraps)
//   o_cnt_mispredict      mispredicted legal branches (wraps)
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned PC_LSB      = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_pf_pc,
  output logic            o_pf_taken,
  input  logic            i_rs_valid,
  input  logic [XLEN-1:0] i_rs_pc,
  input  logic [XLEN-1:0] i_rs_a,
  input  logic [XLEN-1:0] i_rs_b,
  input  logic [2:0]      i_rs_funct3,
  input  logic            i_rs_pred_taken,
  output logic            o_res_valid,
  output logic            o_res_taken,
  output logic            o_res_mispredict,
  output logic            o_res_illegal,
  output logic [31:0]     o_cnt_branch,
  output logic [31:0]     o_cnt_mispredict
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic [1:0]      r_bht [BHT_ENTRIES];
  logic            r_res_valid;
  logic            r_res_taken;
  logic            r_res_mispredict;
  logic            r_res_illegal;
  logic [31:0]     r_cnt_branch;
  logic [31:0]     r_cnt_mispredict;

  logic [IdxW-1:0] w_pf_idx;
  logic [IdxW-1:0] w_rs_idx;
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;
  logic            w_legal;
  logic            w_taken;
  logic            w_mispredict;
  logic            w_update;

  assign w_pf_idx = i_pf_pc[PC_LSB +: IdxW];
  assign w_rs_idx = i_rs_pc[PC_LSB +: IdxW];

  // No bypass: a same-cycle write to this index is seen next cycle.
  assign o_pf_taken = r_bht[w_pf_idx][1];

  assign w_eq   = (i_rs_a == i_rs_b);
  assign w_lt_s = ($signed(i_rs_a) < $signed(i_rs_b));
  assign w_lt_u = (i_rs_a < i_rs_b);

  always_comb begin
    w_taken = 1'b0;
    w_legal = 1'b1;
    case (i_rs_funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = ~w_eq;
      3'b100:  w_taken = w_lt_s;
      3'b101:  w_taken = ~w_lt_s;
      3'b110:  w_taken = w_lt_u;
      3'b111:  w_taken = ~w_lt_u;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_mispredict = w_taken ^ i_rs_pred_taken;
  assign w_update     = i_rs_valid & w_legal;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bht            <= '{default: 2'b01};
      r_res_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_illegal    <= 1'b0;
      r_cnt_branch     <= 32'd0;
      r_cnt_mispredict <= 32'd0;
    end else begin
      r_res_valid      <= i_rs_valid;
      r_res_taken      <= w_update & w_taken;
      r_res_mispredict <= w_update & w_mispredict;
      r_res_illegal    <= i_rs_valid & ~w_legal;
      if (w_update) begin
        if (w_taken) begin
          if (r_bht[w_rs_idx] != 2'b11) r_bht[w_rs_idx] <= r_bht[w_rs_idx] + 2'd1;
        end else begin
          if (r_bht[w_rs_idx] != 2'b00) r_bht[w_rs_idx] <= r_bht[w_rs_idx] - 2'd1;
        end
        r_cnt_branch <= r_cnt_branch + 32'd1;
        if (w_mispredict) r_cnt_mispredict <= r_cnt_mispredict + 32'd1;
      end
    end
  end

  assign o_res_valid      = r_res_valid;
  assign o_res_taken      = r_res_taken;
  assign o_res_mispredict = r_res_mispredict;
  assign o_res_illegal    = r_res_illegal;
  assign o_cnt_branch     = r_cnt_branch;
  assign o_cnt_mispredict = r_cnt_mispredict;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus random traffic,
// checked against a behavioural model of the BHT, outcome and counters.
module tb_branch_resolve_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned PC_LSB  = 2;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] pf_pc;
  logic            pf_taken;
  logic            rs_valid;
  logic [XLEN-1:0] rs_pc;
  logic [XLEN-1:0] rs_a;
  logic [XLEN-1:0] rs_b;
  logic [2:0]      rs_funct3;
  logic            rs_pred_taken;
  logic            res_valid;
  logic            res_taken;
  logic            res_mispredict;
  logic            res_illegal;
  logic [31:0]     cnt_branch;
  logic [31:0]     cnt_mispredict;

  branch_resolve_unit #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (ENTRIES),
    .PC_LSB      (PC_LSB)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_pf_pc          (pf_pc),
    .o_pf_taken       (pf_taken),
    .i_rs_valid       (rs_valid),
    .i_rs_pc          (rs_pc),
    .i_rs_a           (rs_a),
    .i_rs_b           (rs_b),
    .i_rs_funct3      (rs_funct3),
    .i_rs_pred_taken  (rs_pred_taken),
    .o_res_valid      (res_valid),
    .o_res_taken      (res_taken),
    .o_res_mispredict (res_mispredict),
    .o_res_illegal    (res_illegal),
    .o_cnt_branch     (cnt_branch),
    .o_cnt_mispredict (cnt_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: counters held as plain integers 0..3.
  int          m_bht [ENTRIES];
  logic [31:0] m_cnt_b;
  logic [31:0] m_cnt_m;
  bit          m_known = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc / (1 << PC_LSB)) % ENTRIES);
  endfunction

  // Returns -1 for illegal funct3, else 0/1 outcome.
  function automatic int ref_outcome(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    int          sa = a;
    int          sb = b;
    longint      ua = {32'd0, a};
    longint      ub = {32'd0, b};
    case (f3)
      3'd0:    return (ua == ub) ? 1 : 0;
      3'd1:    return (ua != ub) ? 1 : 0;
      3'd4:    return (sa < sb) ? 1 : 0;
      3'd5:    return (sa >= sb) ? 1 : 0;
      3'd6:    return (ua < ub) ? 1 : 0;
      3'd7:    return (ua >= ub) ? 1 : 0;
      default: return -1;
    endcase
  endfunction

  // One clock: drive inputs, check the pre-edge prediction, advance the model,
  // then check registered results and the post-edge prediction.
  task automatic cyc(input logic r, input logic v, input logic [XLEN-1:0] pc,
                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [2:0] f3, input logic pred, input logic [XLEN-1:0] pfpc);
    int   o;
    logic e_valid, e_taken, e_mis, e_ill;
    rst = r; rs_valid = v; rs_pc = pc; rs_a = a; rs_b = b;
    rs_funct3 = f3; rs_pred_taken = pred; pf_pc = pfpc;
    #1;
    if (m_known) check("pf_taken_pre", {31'd0, pf_taken}, {31'd0, m_bht[idx_of(pfpc)] >= 2});
    o = ref_outcome(f3, a, b);
    e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0;
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
      m_cnt_b = 0;
      m_cnt_m = 0;
      m_known = 1;
    end else if (v) begin
      e_valid = 1;
      if (o < 0) begin
        e_ill = 1;
      end else begin
        e_taken = (o == 1);
        e_mis   = e_taken ^ pred;
        if (e_taken) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] < 3) ? m_bht[idx_of(pc)] + 1 : 3;
        else         m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] > 0) ? m_bht[idx_of(pc)] - 1 : 0;
        m_cnt_b = m_cnt_b + 1;
        if (e_mis) m_cnt_m = m_cnt_m + 1;
      end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      check("res_valid",      {31'd0, res_valid},      {31'd0, e_valid});
      check("res_taken",      {31'd0, res_taken},      {31'd0, e_taken});
      check("res_mispredict", {31'd0, res_mispredict}, {31'd0, e_mis});
      check("res_illegal",    {31'd0, res_illegal},    {31'd0, e_ill});
      check("cnt_branch",     cnt_branch,              m_cnt_b);
      check("cnt_mispredict", cnt_mispredict,          m_cnt_m);
      check("pf_taken_post",  {31'd0, pf_taken},       {31'd0, m_bht[idx_of(pfpc)] >= 2});
    end
    @(negedge clk);
  endtask

  logic [2:0]  f3_tab [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] ra, rb, rpc;

  initial begin
    rst = 1; rs_valid = 0; rs_pc = 0; rs_a = 0; rs_b = 0;
    rs_funct3 = 0; rs_pred_taken = 0; pf_pc = 0;
    @(negedge clk);

    // Reset, then lookup and first resolve.
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h100);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h100);
    cyc(0, 1, 32'h100, 5, 5, 3'd0, 0, 32'h100);

    // All six conditions, a=-1/b=1 then a==b.
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 32'h4 * (i + 1), 32'hFFFF_FFFF, 32'h1, f3_tab[i], 1'($urandom), 32'h4 * (i + 1));
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 32'h4 * (i + 1), 32'h7, 32'h7, f3_tab[i], 1'($urandom), 32'h4 * (i + 1));

    // Saturation at 0x40: 4 taken then 3 not-taken.
    for (int i = 0; i < 4; i++) cyc(0, 1, 32'h40, 3, 3, 3'd0, 1, 32'h40);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h40, 3, 3, 3'd1, 1, 32'h40);

    // Illegal funct3.
    cyc(0, 1, 32'h40, 3, 3, 3'b010, 1, 32'h40);
    cyc(0, 1, 32'h40, 3, 4, 3'b011, 1, 32'h40);

    // Read/write collision at 0x80 (counter still at reset value 01).
    cyc(0, 1, 32'h80, 9, 9, 3'd0, 0, 32'h80);
    cyc(0, 0, 32'h80, 0, 0, 3'd0, 0, 32'h80);

    // Reset mid-stream with a valid branch in the reset cycle.
    cyc(0, 1, 32'h8, 1, 2, 3'd6, 0, 32'h8);
    cyc(0, 1, 32'h8, 1, 2, 3'd6, 0, 32'h8);
    cyc(1, 1, 32'h8, 1, 2, 3'd6, 0, 32'h8);
    cyc(0, 0, 32'h8, 0, 0, 3'd0, 0, 32'h8);
    for (int i = 0; i < ENTRIES; i++) cyc(0, 0, 0, 0, 0, 3'd0, 0, 32'(i * 4));

    // Random traffic with aliasing PCs and occasional resets.
    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra ^ 32'h8000_0000;
      rpc = $urandom_range(0, 63) * 4 + (($urandom_range(0, 1) == 0) ? 32'h0 : 32'h1000);
      cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0), rpc, ra, rb,
          3'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 0) ? rpc : 32'($urandom_range(0, 63) * 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
